fixed_divide: RTL and testbench

Sequential signed fixed-point divider computing q = a / b in the same Q-format as the fixed-point multiplier: operands and result share `fractional_size` fractional bits. It is the inverse operation of the multiplier in the audio datapath, used by gain normalisation and compressor stages for reciprocal and ratio computation. It uses a one-bit-per-cycle restoring algorithm on magnitudes, saturates the result, and exchanges data over valid/ready handshakes on both sides.

---
 rtl/fixed_divide_if.sv | 28 ++
 rtl/fixed_divide.sv | 184 ++++++++++++++++++
 tb/tb_fixed_divide.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fixed_divide_if.sv
// fixed_divide_if: handshake bundle for the sequential fixed-point divider.
//   in_valid/in_ready/a/b        operand channel (source -> divider)
//   out_valid/out_ready/q/flags  result channel  (divider -> consumer)
// master: the environment that supplies operands and consumes results.
// slave:  the divider itself.
interface fixed_divide_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, overflow
  );
endinterface

// File: rtl/fixed_divide.sv
// fixed_divide: signed fixed-point divider, q = a / b, all three values
// carrying fractional_size fractional bits. Restoring division on
// magnitudes, one quotient bit per clock, N = W + fractional_size steps,
// then sign application and saturation into a registered result.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fixed_divide_if.slave: operand and result handshakes
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   CALC  | one restoring step per cycle, N steps total
//   DONE  | out_valid high, result held until out_ready
module fixed_divide #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fixed_divide_if.slave bus
);
  localparam int W  = operand_size;
  localparam int N  = W + fractional_size;
  localparam int CW = $clog2(N);

  localparam logic [N-1:0] MAX_POS_N = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [N-1:0] MIN_MAG_N = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] Q_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN     = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  // Dividend shifts out of the top while quotient bits shift in at the
  // bottom, so after N steps this register holds the quotient magnitude.
  logic [N-1:0]   dividend_q,  dividend_d;
  // The stored remainder is always below the divisor, so W bits suffice;
  // the extra bit only exists in the shifted working value.
  logic [W-1:0]   rem_q,       rem_d;
  logic [W-1:0]   divisor_q,   divisor_d;
  logic           sign_q,      sign_d;
  logic           zero_q,      zero_d;
  logic           a_neg_q,     a_neg_d;
  logic [W-1:0]   q_q,         q_d;
  logic           dbz_q,       dbz_d;
  logic           ovf_q,       ovf_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [W:0]     rem_shift;
  logic           fits;
  logic [W-1:0]   rem_step;
  logic [N-1:0]   quo_step;
  logic [W-1:0]   q_fin;
  logic           dbz_fin;
  logic           ovf_fin;

  // Magnitudes; the most negative value maps to 2^(W-1) as an unsigned W-bit number.
  always_comb begin
    abs_a = bus.a[W-1] ? (~bus.a + 1'b1) : bus.a;
    abs_b = bus.b[W-1] ? (~bus.b + 1'b1) : bus.b;
  end

  // One restoring step.
  always_comb begin
    rem_shift = {rem_q, dividend_q[N-1]};
    fits      = (rem_shift >= {1'b0, divisor_q});
    // When fits, the true difference is below the divisor and fits in W bits.
    rem_step  = fits ? (rem_shift[W-1:0] - divisor_q) : rem_shift[W-1:0];
    quo_step  = {dividend_q[N-2:0], fits};
  end

  // Conversion of the final magnitude (the value produced by the last step).
  always_comb begin
    q_fin   = '0;
    dbz_fin = 1'b0;
    ovf_fin = 1'b0;
    if (zero_q) begin
      q_fin   = a_neg_q ? Q_MIN : Q_MAX;
      dbz_fin = 1'b1;
    end else if (!sign_q && (quo_step > MAX_POS_N)) begin
      q_fin   = Q_MAX;
      ovf_fin = 1'b1;
    end else if (sign_q && (quo_step > MIN_MAG_N)) begin
      q_fin   = Q_MIN;
      ovf_fin = 1'b1;
    end else begin
      q_fin   = sign_q ? (~quo_step[W-1:0] + 1'b1) : quo_step[W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    a_neg_d     = a_neg_q;
    q_d         = q_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dividend_d = {abs_a, {fractional_size{1'b0}}};
          divisor_d  = abs_b;
          sign_d     = bus.a[W-1] ^ bus.b[W-1];
          zero_d     = (bus.b == '0);
          a_neg_d    = bus.a[W-1];
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        rem_d      = rem_step;
        dividend_d = quo_step;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          q_d         = q_fin;
          dbz_d       = dbz_fin;
          ovf_d       = ovf_fin;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      a_neg_q     <= 1'b0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      a_neg_q     <= a_neg_d;
      q_q         <= q_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.q           = q_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_divide.sv
module tb_fixed_divide;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fixed_divide_if #(.W(32)) bus ();

  fixed_divide #(.fractional_size(12), .operand_size(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation with out_ready high and waits for its result.
  // lat counts rising edges from the accept edge to the first out_valid.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] qv, output logic dz,
                         output logic ov, output int lat,
                         output logic rdy_after);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    rdy_after = bus.in_ready;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    qv = bus.q; dz = bus.div_by_zero; ov = bus.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.q !== 32'h0) begin fails++; $display("FAIL reset_q got %h want 00000000", bus.q); end
    tests++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {bus.div_by_zero, bus.overflow}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] qv; logic dz, ov, rdy; int lat;
    run_div(32'd6144, 32'd2048, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'd12288) begin fails++; $display("FAIL basic_q got %h want %h", qv, 32'd12288); end
    tests++; if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL basic_flags got %b want 00", {dz, ov}); end
    tests++; if (lat !== 44) begin fails++; $display("FAIL basic_latency got %0d want 44", lat); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL basic_busy_in_ready got %b want 0", rdy); end
  endtask

  task automatic test_truncation();
    logic [31:0] qv; logic dz, ov, rdy; int lat;
    run_div(32'hFFFFF000, 32'd12288, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'hFFFFFAAB) begin fails++; $display("FAIL trunc_neg_a got %h want fffffaab", qv); end
    tests++; if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL trunc_neg_a_flags got %b want 00", {dz, ov}); end
    run_div(32'd4096, 32'hFFFFD000, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'hFFFFFAAB) begin fails++; $display("FAIL trunc_neg_b got %h want fffffaab", qv); end
    run_div(32'd8192, 32'd4096, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'd8192) begin fails++; $display("FAIL plain_two got %h want 00002000", qv); end
  endtask

  task automatic test_div_zero();
    logic [31:0] qv; logic dz, ov, rdy; int lat;
    run_div(32'd5, 32'd0, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'h7FFFFFFF) begin fails++; $display("FAIL dz_pos_q got %h want 7fffffff", qv); end
    tests++; if ({dz, ov} !== 2'b10) begin fails++; $display("FAIL dz_pos_flags got %b want 10", {dz, ov}); end
    tests++; if (lat !== 44) begin fails++; $display("FAIL dz_latency got %0d want 44", lat); end
    run_div(32'hFFFFFFFB, 32'd0, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'h80000000) begin fails++; $display("FAIL dz_neg_q got %h want 80000000", qv); end
    tests++; if ({dz, ov} !== 2'b10) begin fails++; $display("FAIL dz_neg_flags got %b want 10", {dz, ov}); end
    run_div(32'd0, 32'd0, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'h7FFFFFFF) begin fails++; $display("FAIL dz_zero_q got %h want 7fffffff", qv); end
    tests++; if ({dz, ov} !== 2'b10) begin fails++; $display("FAIL dz_zero_flags got %b want 10", {dz, ov}); end
  endtask

  task automatic test_saturation();
    logic [31:0] qv; logic dz, ov, rdy; int lat;
    run_div(32'h7FFFFFFF, 32'd1, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'h7FFFFFFF) begin fails++; $display("FAIL sat_pos_q got %h want 7fffffff", qv); end
    tests++; if ({dz, ov} !== 2'b01) begin fails++; $display("FAIL sat_pos_flags got %b want 01", {dz, ov}); end
    run_div(32'h80000000, 32'd1, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'h80000000) begin fails++; $display("FAIL sat_neg_q got %h want 80000000", qv); end
    tests++; if ({dz, ov} !== 2'b01) begin fails++; $display("FAIL sat_neg_flags got %b want 01", {dz, ov}); end
    run_div(32'h80000000, 32'h80000000, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'd4096) begin fails++; $display("FAIL min_by_min_q got %h want 00001000", qv); end
    tests++; if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL min_by_min_flags got %b want 00", {dz, ov}); end
  endtask

  task automatic test_backpressure();
    int lat;
    // Let any previous result drain first.
    bus.out_ready = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 200) begin @(posedge clk); #1; lat++; end
    bus.out_ready = 1'b0;
    bus.a = 32'd6144; bus.b = 32'd2048; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 44) begin fails++; $display("FAIL bp_latency got %0d want 44", lat); end
    // Pending operands presented while the result is stalled.
    bus.a = 32'd8192; bus.b = 32'd4096; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.q !== 32'd12288) begin fails++; $display("FAIL bp_hold_q cycle %0d got %h want 00003000", i, bus.q); end
      tests++; if ({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow} !== 4'b1000) begin
        fails++; $display("FAIL bp_hold_ctrl cycle %0d got %b want 1000", i, {bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow});
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release got %b want 01", {bus.out_valid, bus.in_ready}); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_pending_accept got %b want 0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 44) begin fails++; $display("FAIL bp_pending_latency got %0d want 44", lat); end
    tests++; if (bus.q !== 32'd8192) begin fails++; $display("FAIL bp_pending_q got %h want 00002000", bus.q); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] qv; logic dz, ov, rdy; int lat; logic spurious;
    bus.a = 32'd6144; bus.b = 32'd2048; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests++; if ({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow} !== 4'b0100) begin
      fails++; $display("FAIL abort_ctrl got %b want 0100", {bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow});
    end
    tests++; if (bus.q !== 32'h0) begin fails++; $display("FAIL abort_q got %h want 00000000", bus.q); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    spurious = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious = 1'b1;
    end
    tests++; if (spurious !== 1'b0) begin fails++; $display("FAIL abort_spurious_valid got %b want 0", spurious); end
    run_div(32'd4096, 32'd4096, qv, dz, ov, lat, rdy);
    tests++; if (qv !== 32'd4096) begin fails++; $display("FAIL abort_next_q got %h want 00001000", qv); end
    tests++; if (lat !== 44) begin fails++; $display("FAIL abort_next_latency got %0d want 44", lat); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_truncation();
    test_div_zero();
    test_saturation();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
